// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 front end.
//   XLEN          : datapath width
//   NOP_INSTR     : addi x0,x0,0 -- the bubble the fetch unit and the
//                   instruction mux flush path both insert
//   RESET_PC      : default boot address
//   fetch_entry_t : {pc, instr} pair held in the fetch buffer
//   word_align()  : clears the byte-offset bits of an address
package msrv32_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs between the instruction
// memory response port and the decode-facing output register.
//   clk, rst            : clock, synchronous active-high reset
//   clear               : synchronous flush; wins over push/pop
//   push, push_pc,
//   push_instr          : write one entry
//   pop                 : drop the head entry
//   head_pc, head_instr : current head (valid when !empty)
//   count, empty, full  : occupancy
module msrv32_fetch_fifo
   import msrv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic [XLEN-1:0]        push_pc,
   input  logic [XLEN-1:0]        push_instr,
   input  logic                   pop,
   output logic [XLEN-1:0]        head_pc,
   output logic [XLEN-1:0]        head_instr,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear && !rst) begin
         mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
      end
   end

   assign head_pc    = mem[rd_ptr].pc;
   assign head_instr = mem[rd_ptr].instr;
   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/msrv32_instr_fetch.sv
// Instruction fetch front end. Streams sequential word requests to
// instruction memory (req/gnt/rvalid), buffers the in-order responses and
// presents one instruction per cycle with its PC to decode. A redirect
// squashes the stream: buffered words are cleared and responses to
// requests already in flight are counted off and dropped.
//   clk_in, rst_in                  : clock, synchronous active-high reset
//   redirect_in, redirect_pc_in     : restart fetch at a new address
//   stall_in                        : decode stalled, hold outputs
//   imem_req_out, imem_addr_out,
//   imem_gnt_in                     : request channel
//   imem_rvalid_in, imem_rdata_in   : response channel
//   instr_out, pc_out, flush_out    : to the instruction mux
module msrv32_instr_fetch
   import msrv32_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_ADDR = RESET_PC,
   parameter int              DEPTH     = 2
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            redirect_in,
   input  logic [XLEN-1:0] redirect_pc_in,
   input  logic            stall_in,
   output logic            imem_req_out,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_gnt_in,
   input  logic            imem_rvalid_in,
   input  logic [XLEN-1:0] imem_rdata_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic            flush_out
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   fifo_count;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] rsp_addr;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;
   logic            fifo_empty;
   logic            fifo_full;
   logic            grant;
   logic            push;
   logic            pop;
   logic [CW-1:0]   gnt_inc;
   logic [CW-1:0]   rsp_dec;
   logic [CW:0]     occupancy;

   assign grant   = imem_req_out & imem_gnt_in;
   assign gnt_inc = {{(CW-1){1'b0}}, grant};
   assign rsp_dec = {{(CW-1){1'b0}}, imem_rvalid_in};

   // Only responses to live requests enter the buffer; the full guard is
   // defensive, credit accounting keeps it from ever firing.
   assign push = imem_rvalid_in & (discard == '0) & !redirect_in & !fifo_full;
   assign pop  = !redirect_in & !stall_in & !fifo_empty;

   // A word leaving the buffer this cycle frees its slot immediately, which
   // is what lets a two-entry buffer sustain one instruction per cycle.
   assign occupancy    = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
   assign imem_req_out = !rst_in & !redirect_in & (occupancy < CREDITS);
   assign imem_addr_out = req_addr;

   msrv32_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk_in),
      .rst        (rst_in),
      .clear      (redirect_in),
      .push       (push),
      .push_pc    (rsp_addr),
      .push_instr (imem_rdata_in),
      .pop        (pop),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

   // rsp_addr tracks the address of the oldest live outstanding request;
   // requests are strictly sequential between redirects, so it only needs
   // to advance by one word per accepted response.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         outstanding <= '0;
         discard     <= '0;
         req_addr    <= word_align(BOOT_ADDR);
         rsp_addr    <= word_align(BOOT_ADDR);
         instr_out   <= NOP_INSTR;
         pc_out      <= BOOT_ADDR;
         flush_out   <= 1'b1;
      end else if (redirect_in) begin
         // Everything still in flight is stale; a response arriving right
         // now is one of them and is consumed here.
         req_addr    <= word_align(redirect_pc_in);
         rsp_addr    <= word_align(redirect_pc_in);
         outstanding <= outstanding - rsp_dec;
         discard     <= outstanding - rsp_dec;
         instr_out   <= NOP_INSTR;
         flush_out   <= 1'b1;
      end else begin
         if (grant) req_addr <= req_addr + 32'd4;
         outstanding <= outstanding + gnt_inc - rsp_dec;
         if (imem_rvalid_in) begin
            if (discard != '0) discard  <= discard - CW'(1);
            else               rsp_addr <= rsp_addr + 32'd4;
         end
         if (!stall_in) begin
            if (pop) begin
               instr_out <= head_instr;
               pc_out    <= head_pc;
               flush_out <= 1'b0;
            end else begin
               instr_out <= NOP_INSTR;
               flush_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_msrv32_instr_fetch.sv
module tb_msrv32_instr_fetch;
   import msrv32_pkg::*;

   localparam logic [31:0] BOOT = 32'h0000_0000;
   localparam logic [31:0] KEY  = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        flush;

   msrv32_instr_fetch #(
      .BOOT_ADDR (BOOT),
      .DEPTH     (2)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .redirect_in    (redirect),
      .redirect_pc_in (redirect_pc),
      .stall_in       (stall),
      .imem_req_out   (req),
      .imem_addr_out  (addr),
      .imem_gnt_in    (gnt),
      .imem_rvalid_in (rvalid),
      .imem_rdata_in  (rdata),
      .instr_out      (instr),
      .pc_out         (pc),
      .flush_out      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          gcyc;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          ready;
   } exp_t;

   pend_t pend[$];
   exp_t  exp_q[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   bit          gnt_en;
   bit          rsp_en;
   bit          last_req;
   logic [31:0] exp_gaddr;
   bit          p_rst, p_redir, p_stall;
   logic [31:0] p_instr, p_pc;
   logic        p_flush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic check_outputs();
      exp_t ee;
      if (p_rst) begin
         chk("rst_flush", {31'b0, flush}, 32'd1);
         chk("rst_instr", instr, NOP_INSTR);
         chk("rst_pc", pc, BOOT);
      end else if (p_redir) begin
         chk("redir_flush", {31'b0, flush}, 32'd1);
         chk("redir_instr", instr, NOP_INSTR);
         chk("redir_pc_hold", pc, p_pc);
      end else if (p_stall) begin
         chk("stall_instr", instr, p_instr);
         chk("stall_pc", pc, p_pc);
         chk("stall_flush", {31'b0, flush}, {31'b0, p_flush});
      end else if (flush === 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_instr", {31'b0, flush}, 32'd1);
         end else begin
            ee = exp_q.pop_front();
            chk("sb_pc", pc, ee.pc);
            chk("sb_instr", instr, ee.instr);
         end
      end else begin
         chk("bubble_instr", instr, NOP_INSTR);
         if (exp_q.size() > 0 && exp_q[0].ready < cyc)
            chk("missed_instr", {31'b0, flush}, 32'd0);
      end
   endtask

   // One clock: memory model response, grant bookkeeping, scoreboard update,
   // then output check half a cycle after the edge.
   task automatic step();
      pend_t pe;
      exp_t  ee;
      rvalid = 1'b0;
      rdata  = '0;
      if (rsp_en && pend.size() > 0 && pend[0].gcyc < cyc) begin
         pe     = pend.pop_front();
         rvalid = 1'b1;
         rdata  = pe.addr ^ KEY;
         if (!pe.stale && !redirect && !rst) begin
            ee.pc    = pe.addr;
            ee.instr = pe.addr ^ KEY;
            ee.ready = cyc + 1;
            exp_q.push_back(ee);
         end
      end
      gnt = gnt_en;
      #1;
      last_req = (req === 1'b1);
      if (req === 1'b1 && gnt) begin
         chk("gnt_addr", addr, exp_gaddr);
         pe.addr  = addr;
         pe.stale = 1'b0;
         pe.gcyc  = cyc;
         pend.push_back(pe);
         exp_gaddr += 32'd4;
      end
      if (redirect) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_q.delete();
         exp_gaddr = {redirect_pc[31:2], 2'b00};
      end
      if (rst) begin
         pend.delete();
         exp_q.delete();
         exp_gaddr = BOOT;
      end
      p_rst   = rst;
      p_redir = redirect;
      p_stall = stall;
      p_instr = instr;
      p_pc    = pc;
      p_flush = flush;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic wait_first(input string tag, input logic [31:0] exp_pc);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (flush !== 1'b0 && n < 20);
      chk({tag, "_first_valid"}, {31'b0, flush}, 32'd0);
      chk({tag, "_first_pc"}, pc, exp_pc);
   endtask

   initial begin
      int first, bubbles, n;
      logic [31:0] a0;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      gnt_en = 1'b0; rsp_en = 1'b0; exp_gaddr = BOOT;
      @(negedge clk);
      step();
      step();
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_addr", addr, BOOT);

      // streaming after reset
      rst = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
      first = 0; bubbles = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (flush === 1'b0 && first == 0) first = i;
         else if (first != 0 && flush !== 1'b0) bubbles++;
      end
      chk("latency", first, 3);
      chk("stream_bubbles", bubbles, 0);

      // stall for three cycles
      stall = 1'b1;
      step();
      step();
      chk("stall_req_low", {31'b0, last_req}, 32'd0);
      step();
      chk("stall_req_low3", {31'b0, last_req}, 32'd0);
      stall = 1'b0;
      repeat (6) step();

      // grant withheld
      gnt_en = 1'b0;
      step();
      a0 = addr;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gnt_low_addr", addr, a0);
      end
      chk("gnt_low_req", {31'b0, last_req}, 32'd1);
      chk("gnt_low_bubble", {31'b0, flush}, 32'd1);
      gnt_en = 1'b1;
      repeat (4) step();

      // redirect with two requests in flight
      rsp_en = 1'b0;
      n = 0;
      while (pend.size() < 2 && n < 10) begin
         step();
         n++;
      end
      chk("t4_inflight", pend.size(), 2);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      chk("redir_req_low", {31'b0, last_req}, 32'd0);
      redirect = 1'b0;
      chk("redir_addr", addr, 32'h0000_0100);
      rsp_en = 1'b1;
      wait_first("t4", 32'h0000_0100);
      repeat (3) step();

      // redirect coinciding with a response and a stall
      rsp_en = 1'b0;
      repeat (3) step();
      chk("t5_inflight", {31'b0, pend.size() > 0}, 32'd1);
      rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1;
      step();
      redirect = 1'b0;
      step();
      stall = 1'b0;
      wait_first("t5", 32'h0000_0200);
      repeat (3) step();

      // address wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect = 1'b0;
      wait_first("wrap", 32'hFFFF_FFF8);
      repeat (4) step();

      // reset with the buffer full
      stall = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("t6_req", {31'b0, req}, 32'd0);
      chk("t6_addr", addr, BOOT);
      step();
      rst = 1'b0; stall = 1'b0;
      wait_first("t6", BOOT);
      repeat (4) step();

      // drain: every accepted word must have come out
      gnt_en = 1'b0;
      repeat (6) step();
      chk("final_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
